// File: rtl/csc_enc_hls_deadlock_reporter.sv
// Deadlock reporter for the csc_enc HLS monitors: filters transient stalls, confirms a deadlock
// after THRESH consecutive blocked cycles, and emits one report beat over valid/ready.
module csc_enc_hls_deadlock_reporter #(
    parameter int NUM_MON = 4,
    parameter int THRESH  = 1024,
    parameter int CNT_W   = 16,
    localparam int ID_W   = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_MON-1:0]      monitor_block,
    input  logic                    clear,
    output logic                    deadlock_detected,
    output logic [ID_W-1:0]         deadlock_id,
    output logic [CNT_W-1:0]        stall_cycles,
    output logic                    report_valid,
    input  logic                    report_ready,
    output logic [ID_W+CNT_W-1:0]   report_data
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    typedef enum logic [1:0] {IDLE, WATCH, REPORT, HOLD} state_t;

    state_t                  state, state_n;
    logic [ID_W-1:0]         cand, cand_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [ID_W-1:0]         id_n;
    logic                    det_n;
    logic                    vld_n;
    logic [ID_W+CNT_W-1:0]   data_n;

    logic                    cand_hit;
    logic                    any_block;
    logic [ID_W-1:0]         low_idx;
    logic [CNT_W-1:0]        cnt_inc;

    function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_MON-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

    // Loop-based select keeps the lookup in range when NUM_MON is not a power of two.
    function automatic logic bit_at(input logic [NUM_MON-1:0] v, input logic [ID_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NUM_MON; i++) begin
            if (ID_W'(i) == idx) b = v[i];
        end
        return b;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign cand_hit     = bit_at(monitor_block, cand);
    assign any_block    = |monitor_block;
    assign low_idx      = lowest_set(monitor_block);
    assign cnt_inc      = sat_inc(cnt);
    assign stall_cycles = cnt;

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        det_n   = deadlock_detected;
        id_n    = deadlock_id;
        vld_n   = report_valid;
        data_n  = report_data;
        if (clear) begin
            state_n = IDLE;
            cand_n  = '0;
            cnt_n   = '0;
            det_n   = 1'b0;
            id_n    = '0;
            vld_n   = 1'b0;
            data_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_block) begin
                        cand_n  = low_idx;
                        cnt_n   = CNT_W'(1);
                        state_n = WATCH;
                    end else begin
                        cnt_n = '0;
                    end
                end
                WATCH: begin
                    if (cand_hit) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == THRESH_C) begin
                            state_n = REPORT;
                            det_n   = 1'b1;
                            id_n    = cand;
                            vld_n   = 1'b1;
                            data_n  = {cand, THRESH_C};
                        end
                    end else if (any_block) begin
                        // Candidate released while another monitor is stalled: restart on it.
                        cand_n = low_idx;
                        cnt_n  = CNT_W'(1);
                    end else begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
                REPORT: begin
                    if (cand_hit) cnt_n = cnt_inc;
                    if (report_ready) begin
                        vld_n   = 1'b0;
                        state_n = HOLD;
                    end
                end
                HOLD: begin
                    if (cand_hit) cnt_n = cnt_inc;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            cand              <= '0;
            cnt               <= '0;
            deadlock_detected <= 1'b0;
            deadlock_id       <= '0;
            report_valid      <= 1'b0;
            report_data       <= '0;
        end else begin
            state             <= state_n;
            cand              <= cand_n;
            cnt               <= cnt_n;
            deadlock_detected <= det_n;
            deadlock_id       <= id_n;
            report_valid      <= vld_n;
            report_data       <= data_n;
        end
    end

endmodule
